store_align_buffer: RTL and testbench
=====================================

# store_align_buffer

Store-path formatter and buffer for the ARC MIPS data memory interface; it performs the reverse of immediate/load sign extension. Takes a 32-bit register value, an address and an access size from the MEM stage, narrows the value to byte/halfword/word, replicates it across lanes with byte enables, and queues it in a small FIFO. A valid/ready handshake connects the FIFO to data memory. It optionally detects misaligned stores and raises the MIPS address-error-on-store exception.

## Interface
- DEPTH, 2, number of buffered stores (power of two, ≥2)
- AW, 32, address width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- i_st_valid  in  1  store request from MEM stage
- o_st_ready  out  1  buffer can accept; equals !full, 0 while reset asserted
- i_st_addr  in  AW  byte address
- i_st_data  in  32  rt register value; low bits used per size
- i_st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- o_mem_valid  out  1  head entry present
- i_mem_ready  in  1  memory accepts head entry
- o_mem_addr  out  AW  {addr[AW-1:2],2'b00}
- o_mem_wdata  out  32  lane-replicated data
- o_mem_be  out  4  byte enables, bit n = byte lane n (little-endian)
- o_exc_ades  out  1  one-cycle misaligned-store pulse
- o_exc_badvaddr  out  AW  faulting address, held until next fault
- o_empty  out  1  no entries queued

## Operation
- Accept on i_st_valid & o_st_ready at a rising edge.
- Byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
- Half: wdata={2{data[15:0]}}, be=addr[1]?4'b1100:4'b0011.
- Word/reserved: wdata=data, be=4'b1111.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11 at any address.
- FIFO: write/read pointers of log2(DEPTH) bits wrap modulo DEPTH; count 0..DEPTH. Occupancy states EMPTY (count 0), PARTIAL, FULL (count DEPTH).
  - Push only: count+1.
  - Pop (o_mem_valid & i_mem_ready) only: count-1.
  - Push and pop together: count unchanged, both pointers advance.
- No push is accepted when FULL, even if a pop occurs in the same cycle; there is no pass-through.
- Head outputs come straight from storage, are never combinationally dependent on inputs, and stay stable while o_mem_valid & !i_mem_ready.
- Reset values: count 0, pointers 0, o_mem_valid 0, o_empty 1, o_exc_ades 0, o_exc_badvaddr 0, addr/wdata/be 0.
- Reset asserted mid-operation discards all queued entries; no memory write completes after reset assertion.

## Timing
- Push at edge N → o_mem_valid=1 from cycle N+1 (latency 1), if the FIFO was empty.
- Pop at edge N → the next entry is on the outputs in cycle N+1; o_mem_valid falls in N+1 if that was the last entry.
- o_st_ready rises in the cycle after the pop that leaves FULL.
- Exception: a fault accepted at edge N gives o_exc_ades=1 during cycle N+1 only, with o_exc_badvaddr updated at edge N.
- Throughput: one store per cycle sustained when i_mem_ready=1.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - A misaligned request is consumed (ready handshake completes) but not enqueued.
  - o_exc_ades pulses and o_exc_badvaddr captures i_st_addr.
- Not defined:
  - No misalignment checks. Low address bits the size does not use are ignored: half uses addr[1] only, word ignores addr[1:0], and size 11 is treated as a word.
  - o_exc_ades is tied 0 and o_exc_badvaddr is tied 0.

## Structure
- arc_pkg holds:
  - enum st_size_e {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11}
  - typedef struct st_entry_t {addr, wdata, be}
  - localparam BE_ALL=4'b1111
- Sub-module store_lane_fmt: combinational size/addr → wdata, be, misaligned. Instantiated once at the FIFO input.

## Test plan
- Byte at 0x1003, data 0xDEADBEEF → addr 0x1000, wdata 0xEFEFEFEF, be 4'b1000, o_mem_valid one cycle after accept.
- Half at 0x2002, data 0x1234ABCD → wdata 0xABCDABCD, be 4'b1100. Word at 0x2004 → be 4'b1111.
- i_mem_ready=0 with three pushes (DEPTH=2) → o_st_ready=0 after the second; the third is held. Release ready → order preserved, third accepted the cycle after the first pop.
- Push and pop in the same cycle with count=1 → count stays 1, with correct data order across pointer wrap.
- With STORE_MISALIGN_TRAP_EN: word at 0x3001 → o_exc_ades high exactly one cycle, badvaddr 0x3001, o_empty stays 1. Without the macro: word write to 0x3000, be 4'b1111.
- Reset asserted with 2 queued and i_mem_ready=0 → o_mem_valid=0 and o_empty=1 immediately; no write is observed after reset is released.

Source files
------------

// File: rtl/arc_pkg.sv
// arc_pkg: shared store-path types and constants for the ARC MIPS data memory interface.
package arc_pkg;
   localparam int ADDR_W = 32;
   localparam logic [3:0] BE_ALL = 4'b1111;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} st_size_e;
   typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        be;
   } st_entry_t;
endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: narrows a store value to its size, replicates it across lanes and builds byte enables.
module store_lane_fmt
   import arc_pkg::*;
(
`ifdef STORE_MISALIGN_TRAP_EN
   output logic        misaligned,
`endif
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be
);
   always_comb begin
      wdata = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
      be    = size == SZ_BYTE ? 4'b0001 << addr_lo : size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : BE_ALL;
`ifdef STORE_MISALIGN_TRAP_EN
      misaligned = size == SZ_HALF ? addr_lo[0] : size == SZ_WORD ? |addr_lo : size == SZ_RSVD;
`endif
   end
endmodule

// File: rtl/store_align_buffer.sv
// store_align_buffer: formats MEM-stage stores and queues them for data memory.
// Misaligned-store trapping is enabled by defining STORE_MISALIGN_TRAP_EN.
module store_align_buffer
   import arc_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_st_valid,
   output logic          o_st_ready,
   input  logic [AW-1:0] i_st_addr,
   input  logic [31:0]   i_st_data,
   input  logic [1:0]    i_st_size,
   output logic          o_mem_valid,
   input  logic          i_mem_ready,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_mem_wdata,
   output logic [3:0]    o_mem_be,
   output logic          o_exc_ades,
   output logic [AW-1:0] o_exc_badvaddr,
   output logic          o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   occ_e            occ_q, occ_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_q, rd_q;
   st_entry_t       mem_q [DEPTH];
   st_entry_t       ent, head;
   logic [31:0]     fmt_wdata;
   logic [3:0]      fmt_be;
   logic            full, acc, push, pop;
   assign acc = i_st_valid & o_st_ready;
   assign pop = o_mem_valid & i_mem_ready;
`ifdef STORE_MISALIGN_TRAP_EN
   logic mis, ades_q;
   logic [AW-1:0] badv_q;
   store_lane_fmt u_fmt (.misaligned(mis), .addr_lo(i_st_addr[1:0]), .size(i_st_size), .data(i_st_data), .wdata(fmt_wdata), .be(fmt_be));
   assign push = acc & !mis;
   // A misaligned store completes its handshake but is dropped, leaving only the exception.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ades_q <= 1'b0;
         badv_q <= '0;
      end else begin
         ades_q <= acc & mis;
         if (acc & mis) badv_q <= i_st_addr;
      end
   end
   assign o_exc_ades = ades_q;
   assign o_exc_badvaddr = badv_q;
`else
   store_lane_fmt u_fmt (.addr_lo(i_st_addr[1:0]), .size(i_st_size), .data(i_st_data), .wdata(fmt_wdata), .be(fmt_be));
   assign push = acc;
   assign o_exc_ades = 1'b0;
   assign o_exc_badvaddr = '0;
`endif
   assign ent = '{addr: ADDR_W'({i_st_addr[AW-1:2], 2'b00}), wdata: fmt_wdata, be: fmt_be};
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ_q <= OCC_EMPTY;
         cnt_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
      end else begin
         occ_q <= occ_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_q + PW'(push);
         rd_q  <= rd_q + PW'(pop);
      end
   end
   always_comb begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      occ_d = cnt_d == '0 ? OCC_EMPTY : cnt_d == CW'(DEPTH) ? OCC_FULL : OCC_PARTIAL;
   end
   always_comb begin
      full        = occ_q == OCC_FULL;
      o_empty     = occ_q == OCC_EMPTY;
      o_mem_valid = !o_empty;
      o_st_ready  = !full & !reset;
   end
   // Storage is cleared on reset so the head outputs read as zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_q] <= ent;
      end
   end
   assign head        = mem_q[rd_q];
   assign o_mem_addr  = head.addr[AW-1:0];
   assign o_mem_wdata = head.wdata;
   assign o_mem_be    = head.be;
endmodule

// File: tb/tb_store_align_buffer.sv
// tb_store_align_buffer: directed self-checking bench for store_align_buffer (DEPTH 2, AW 32).
module tb_store_align_buffer;
   logic        clock, reset;
   logic        i_st_valid, o_st_ready;
   logic [31:0] i_st_addr, i_st_data;
   logic [1:0]  i_st_size;
   logic        o_mem_valid, i_mem_ready;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        o_exc_ades;
   logic [31:0] o_exc_badvaddr;
   logic        o_empty;
   int checks = 0;
   int errors = 0;
   store_align_buffer #(.DEPTH(2), .AW(32)) dut (
      .clock(clock), .reset(reset),
      .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
      .i_st_addr(i_st_addr), .i_st_data(i_st_data), .i_st_size(i_st_size),
      .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
      .o_exc_ades(o_exc_ades), .o_exc_badvaddr(o_exc_badvaddr), .o_empty(o_empty)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      i_st_valid = v;
      i_st_addr  = a;
      i_st_data  = d;
      i_st_size  = s;
   endtask
   task automatic head(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
      chk({tag, "_valid"}, 32'(o_mem_valid), 32'd1);
      chk({tag, "_addr"}, o_mem_addr, a);
      chk({tag, "_wdata"}, o_mem_wdata, w);
      chk({tag, "_be"}, 32'(o_mem_be), 32'(b));
   endtask
   initial begin
      reset = 1'b1;
      i_mem_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      tick();
      tick();
      chk("rst_ready", 32'(o_st_ready), 32'd0);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_valid", 32'(o_mem_valid), 32'd0);
      chk("rst_addr", o_mem_addr, 32'h0);
      chk("rst_wdata", o_mem_wdata, 32'h0);
      chk("rst_be", 32'(o_mem_be), 32'h0);
      chk("rst_ades", 32'(o_exc_ades), 32'd0);
      chk("rst_badv", o_exc_badvaddr, 32'h0);
      reset = 1'b0;
      #1;
      chk("idle_ready", 32'(o_st_ready), 32'd1);
      // byte store, latency 1
      drive(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 2'b00);
      #1;
      chk("byte_pre_valid", 32'(o_mem_valid), 32'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      head("byte", 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
      chk("byte_empty", 32'(o_empty), 32'd0);
      i_mem_ready = 1'b1;
      tick();
      chk("byte_pop_empty", 32'(o_empty), 32'd1);
      chk("byte_pop_valid", 32'(o_mem_valid), 32'd0);
      // backpressure: fill, hold a third, then drain in order
      i_mem_ready = 1'b0;
      drive(1'b1, 32'h0000_2002, 32'h1234_ABCD, 2'b01);
      tick();
      drive(1'b1, 32'h0000_2004, 32'h1122_3344, 2'b10);
      tick();
      chk("full_ready", 32'(o_st_ready), 32'd0);
      head("half", 32'h0000_2000, 32'hABCD_ABCD, 4'b1100);
      drive(1'b1, 32'h0000_3000, 32'h0000_0055, 2'b00);
      tick();
      chk("held_ready", 32'(o_st_ready), 32'd0);
      head("half_stable", 32'h0000_2000, 32'hABCD_ABCD, 4'b1100);
      i_mem_ready = 1'b1;
      tick();
      chk("after_pop_ready", 32'(o_st_ready), 32'd1);
      head("word", 32'h0000_2004, 32'h1122_3344, 4'b1111);
      i_mem_ready = 1'b0;
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      chk("third_acc_ready", 32'(o_st_ready), 32'd0);
      head("word_stable", 32'h0000_2004, 32'h1122_3344, 4'b1111);
      i_mem_ready = 1'b1;
      tick();
      head("third", 32'h0000_3000, 32'h5555_5555, 4'b0001);
      chk("third_ready", 32'(o_st_ready), 32'd1);
      // simultaneous push and pop with one entry
      drive(1'b1, 32'h0000_4000, 32'h0000_BEEF, 2'b01);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      head("pushpop", 32'h0000_4000, 32'hBEEF_BEEF, 4'b0011);
      chk("pushpop_ready", 32'(o_st_ready), 32'd1);
      tick();
      chk("pushpop_drain", 32'(o_empty), 32'd1);
      // sustained one store per cycle
      drive(1'b1, 32'h0000_0010, 32'hA1A2_A3A4, 2'b10);
      tick();
      head("stream0", 32'h0000_0010, 32'hA1A2_A3A4, 4'b1111);
      drive(1'b1, 32'h0000_0015, 32'h0000_00B7, 2'b00);
      tick();
      head("stream1", 32'h0000_0014, 32'hB7B7_B7B7, 4'b0010);
      chk("stream1_ready", 32'(o_st_ready), 32'd1);
      drive(1'b1, 32'h0000_0018, 32'h0000_C0DE, 2'b01);
      tick();
      head("stream2", 32'h0000_0018, 32'hC0DE_C0DE, 4'b0011);
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      tick();
      chk("stream_drain", 32'(o_empty), 32'd1);
      // misaligned word
      i_mem_ready = 1'b0;
      drive(1'b1, 32'h0000_3001, 32'hCAFE_F00D, 2'b10);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef STORE_MISALIGN_TRAP_EN
      chk("mis_ades", 32'(o_exc_ades), 32'd1);
      chk("mis_badv", o_exc_badvaddr, 32'h0000_3001);
      chk("mis_empty", 32'(o_empty), 32'd1);
      tick();
      chk("mis_ades_fall", 32'(o_exc_ades), 32'd0);
      chk("mis_badv_hold", o_exc_badvaddr, 32'h0000_3001);
      chk("mis_empty2", 32'(o_empty), 32'd1);
      drive(1'b1, 32'h0000_5002, 32'h0102_0304, 2'b11);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      chk("rsvd_ades", 32'(o_exc_ades), 32'd1);
      chk("rsvd_badv", o_exc_badvaddr, 32'h0000_5002);
      chk("rsvd_empty", 32'(o_empty), 32'd1);
`else
      head("mis_word", 32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
      chk("mis_ades", 32'(o_exc_ades), 32'd0);
      chk("mis_badv", o_exc_badvaddr, 32'h0);
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      drive(1'b1, 32'h0000_5002, 32'h0102_0304, 2'b11);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      head("rsvd_word", 32'h0000_5000, 32'h0102_0304, 4'b1111);
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
`endif
      chk("pre_rst_empty", 32'(o_empty), 32'd1);
      // reset discards queued entries
      drive(1'b1, 32'h0000_6000, 32'h6666_6666, 2'b10);
      tick();
      drive(1'b1, 32'h0000_6004, 32'h7777_7777, 2'b10);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      chk("q2_ready", 32'(o_st_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(o_mem_valid), 32'd0);
      chk("arst_empty", 32'(o_empty), 32'd1);
      chk("arst_ready", 32'(o_st_ready), 32'd0);
      i_mem_ready = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst_valid%0d", i), 32'(o_mem_valid), 32'd0);
      end
      chk("post_rst_ready", 32'(o_st_ready), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
